ofm_writeback: RTL and testbench
================================

Name: ofm_writeback

Overview:
- Sits directly downstream of the postprocessor and upstream of the buffer_manager feature-map write port.
- The postprocessor emits (valid, data, addr) words with no back-pressure. This block absorbs them in a small FIFO and drives them to buffer_manager under a valid/ready handshake.
- Counts the words for one layer and pulses done once the last word has been accepted downstream. Detects and flags overflow and unexpected traffic.

Parameters:
- OFM_DW, `FM_BUFFER_DW, width of one output word.
- OFM_AW, `FM_BUFFER_AW, feature-map buffer address width.
- W_SIZE, `W_SIZE, width/height field width.
- W_CHANNEL, `W_CHANNEL, tiled channel field width.
- FIFO_DEPTH, 16, skid FIFO entries; must be a power of two, ≥4.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle pulse; latches the layer geometry and begins a layer.
- q_width  in  W_SIZE  output width of the layer.
- q_height  in  W_SIZE  output height of the layer.
- q_channel_out  in  W_CHANNEL  tiled output channel count.
- i_pp_data_vld  in  1  word valid from postprocessor.
- i_pp_data  in  OFM_DW  word data.
- i_pp_addr  in  OFM_AW  word address.
- o_wr_vld  out  1  write request to buffer_manager.
- o_wr_data  out  OFM_DW  write data.
- o_wr_addr  out  OFM_AW  write address.
- i_wr_rdy  in  1  buffer_manager accepts the word this cycle.
- o_busy  out  1  high in RUN or DRAIN.
- o_done  out  1  one-cycle pulse at layer completion.
- o_overflow  out  1  sticky flag: a word was dropped because the FIFO was full.
- o_err_unexp  out  1  sticky flag: a word arrived outside RUN.
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, FIFO empty, output stage empty.
- Expected word count: expected = q_width*q_height*q_channel_out.
  - Computed at full precision, 2*W_SIZE+W_CHANNEL bits.
  - Latched on i_start accepted in IDLE.
- Push rule: a word is pushed when i_pp_data_vld && state==RUN && (!full || pop_this_cycle).
  - Push and pop in the same cycle when full is legal; level is unchanged.
- Overflow: i_pp_data_vld in RUN while full and not popping drops the word and sets o_overflow.
  - The word still increments in_count, so layer termination does not hang.
- Unexpected traffic: i_pp_data_vld in IDLE, DRAIN or DONE drops the word and sets o_err_unexp.
- Both sticky flags clear only on an accepted i_start or on reset.
- Output stage: one register holding {data, addr}. o_wr_vld is high when it is occupied.
  - The register is loaded from the FIFO head when it is empty, or when o_wr_vld && i_wr_rdy.
  - While o_wr_vld && !i_wr_rdy, data and addr are held stable.
- Latency with empty FIFO and i_wr_rdy=1:
  - The word is written into the FIFO at edge N.
  - It is loaded into the output stage at edge N+1, so o_wr_vld is high in the cycle after N+1: 2 cycles.
  - Steady-state throughput is 1 word/cycle.
- FSM:
  - IDLE: on i_start go to RUN, with in_count=0. If expected==0, go to DONE instead.
  - RUN: in_count increments on every i_pp_data_vld, pushed or dropped. When in_count+1==expected with vld, go to DRAIN.
  - DRAIN: when the FIFO is empty and the output stage is empty (or being emptied this cycle with a handshake and nothing left to load), go to DONE.
  - DONE: o_done=1 for exactly one cycle, then IDLE.
- o_busy = (state==RUN || state==DRAIN).
- i_start outside IDLE is ignored: no relatch, flags unchanged.
- Reset mid-operation discards FIFO contents and in-flight output with no write completion. This is legal because reset is asynchronous.

Decomposition:
- Shared header controller_params.vh provides the existing `FM_BUFFER_DW, `FM_BUFFER_AW, `W_SIZE and `W_CHANNEL.
- New constants to add there: `OFM_WB_FIFO_DEPTH, plus the FSM state encodings IDLE=0, RUN=1, DRAIN=2, DONE=3.
- One sub-module: sync_fifo (parameterised width/depth, push/pop, full/empty/level; pop data valid at the head in the same cycle).

Test Plan:
- Basic layer: width=2, height=2, channel_out=1, i_wr_rdy=1, 4 back-to-back words at addr 0..3.
  - Required: 4 writes in order, first o_wr_vld 2 cycles after the first vld, o_done pulse after the last write, no flags set.
- Back-pressure: i_wr_rdy=0 for 10 cycles while 8 words arrive.
  - Required: o_fifo_level reaches 7 with 1 in the output stage, o_wr_data/o_wr_addr stable while stalled, all 8 delivered in order after release, o_overflow=0.
- Overflow: i_wr_rdy=0, 20 consecutive words with FIFO_DEPTH=16.
  - Required: 17 retained (16 FIFO + 1 output stage), o_overflow=1, o_done still pulses after the drain once expected=20.
- Full with simultaneous pop: FIFO full, i_wr_rdy=1 and vld in the same cycle.
  - Required: the word is accepted, level stays 16, o_overflow=0.
- Zero and stray traffic: i_start with q_height=0.
  - Required: o_done 2 cycles later.
  - Then vld while IDLE: o_err_unexp=1, no o_wr_vld.
  - Next i_start: o_err_unexp cleared.
- Async reset mid-RUN: assert rstn=0 with level=5.
  - Required: o_wr_vld=0, o_fifo_level=0 and o_busy=0 immediately, with no extra writes after release.

Source files
------------

// File: rtl/ofm_writeback_pkg.sv
// Shared constants and FSM encoding for the output-feature-map writeback path.
package ofm_writeback_pkg;

    localparam int unsigned FM_BUFFER_DW      = 32;
    localparam int unsigned FM_BUFFER_AW      = 12;
    localparam int unsigned DEF_W_SIZE        = 8;
    localparam int unsigned DEF_W_CHANNEL     = 6;
    localparam int unsigned OFM_WB_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } wb_state_e;

endpackage

// File: rtl/ofm_writeback_sync_fifo.sv
// Synchronous FIFO with head data visible combinationally; push while full is
// accepted only when a pop happens in the same cycle.
module ofm_writeback_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         head_c,
    output logic                     full_c,
    output logic                     empty_c,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty_c = (level_q == '0);
    assign full_c  = (level_q == LVL_W'(DEPTH));
    assign head_c  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_comb begin
        pop_ok  = pop_i && !empty_c;
        push_ok = push_i && (!full_c || pop_ok);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by level_q alone.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/ofm_writeback.sv
// Absorbs postprocessor words into a skid FIFO, forwards them to the buffer
// manager under valid/ready, and signals completion of each layer.
module ofm_writeback
    import ofm_writeback_pkg::*;
#(
    parameter int unsigned OFM_DW     = FM_BUFFER_DW,
    parameter int unsigned OFM_AW     = FM_BUFFER_AW,
    parameter int unsigned W_SIZE     = DEF_W_SIZE,
    parameter int unsigned W_CHANNEL  = DEF_W_CHANNEL,
    parameter int unsigned FIFO_DEPTH = OFM_WB_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          i_start,
    input  logic [W_SIZE-1:0]             q_width,
    input  logic [W_SIZE-1:0]             q_height,
    input  logic [W_CHANNEL-1:0]          q_channel_out,
    input  logic                          i_pp_data_vld,
    input  logic [OFM_DW-1:0]             i_pp_data,
    input  logic [OFM_AW-1:0]             i_pp_addr,
    output logic                          o_wr_vld,
    output logic [OFM_DW-1:0]             o_wr_data,
    output logic [OFM_AW-1:0]             o_wr_addr,
    input  logic                          i_wr_rdy,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_overflow,
    output logic                          o_err_unexp,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int unsigned CNT_W = 2 * W_SIZE + W_CHANNEL;
    localparam int unsigned ENT_W = OFM_DW + OFM_AW;

    wb_state_e          state_q, state_d;
    logic [CNT_W-1:0]   expected_q, expected_d;
    logic [CNT_W-1:0]   in_count_q, in_count_d;
    logic [CNT_W-1:0]   expected_c;

    logic               out_vld_q, out_vld_d;
    logic [OFM_DW-1:0]  out_data_q, out_data_d;
    logic [OFM_AW-1:0]  out_addr_q, out_addr_d;
    logic               overflow_q, overflow_d;
    logic               err_unexp_q, err_unexp_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               start_ok_c;
    logic               run_vld_c;
    logic               drop_c;
    logic               fifo_push_c;
    logic               fifo_pop_c;
    logic               fifo_full_c;
    logic               fifo_empty_c;
    logic [ENT_W-1:0]   fifo_head_c;
    logic [OFM_DW-1:0]  head_data_c;
    logic [OFM_AW-1:0]  head_addr_c;

    assign expected_c  = CNT_W'(q_width) * CNT_W'(q_height) * CNT_W'(q_channel_out);
    assign start_ok_c  = i_start && (state_q == ST_IDLE);
    assign run_vld_c   = i_pp_data_vld && (state_q == ST_RUN);
    // The output stage refills whenever it is empty or is handing off this cycle.
    assign fifo_pop_c  = !fifo_empty_c && (!out_vld_q || i_wr_rdy);
    assign fifo_push_c = run_vld_c && (!fifo_full_c || fifo_pop_c);
    assign drop_c      = run_vld_c && !fifo_push_c;
    assign {head_data_c, head_addr_c} = fifo_head_c;

    ofm_writeback_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (fifo_push_c),
        .pop_i   (fifo_pop_c),
        .wdata_i ({i_pp_data, i_pp_addr}),
        .head_c  (fifo_head_c),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c),
        .level_o (o_fifo_level)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            expected_q <= '0;
            in_count_q <= '0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            in_count_q <= in_count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        in_count_d = in_count_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    expected_d = expected_c;
                    in_count_d = '0;
                    state_d    = (expected_c == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                // Dropped words still count so a lossy layer still terminates.
                if (i_pp_data_vld) begin
                    in_count_d = in_count_q + CNT_W'(1);
                    if ((in_count_q + CNT_W'(1)) == expected_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty_c && (!out_vld_q || i_wr_rdy)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_vld_d   = out_vld_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        overflow_d  = overflow_q;
        err_unexp_d = err_unexp_q;
        busy_d      = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d      = (state_q == ST_DONE);
        if (fifo_pop_c) begin
            out_vld_d  = 1'b1;
            out_data_d = head_data_c;
            out_addr_d = head_addr_c;
        end else if (out_vld_q && i_wr_rdy) begin
            out_vld_d = 1'b0;
        end
        if (start_ok_c) begin
            overflow_d  = 1'b0;
            err_unexp_d = 1'b0;
        end
        if (drop_c) begin
            overflow_d = 1'b1;
        end
        if (i_pp_data_vld && (state_q != ST_RUN)) begin
            err_unexp_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            overflow_q  <= 1'b0;
            err_unexp_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            out_vld_q   <= out_vld_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            overflow_q  <= overflow_d;
            err_unexp_q <= err_unexp_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign o_wr_vld    = out_vld_q;
    assign o_wr_data   = out_data_q;
    assign o_wr_addr   = out_addr_q;
    assign o_overflow  = overflow_q;
    assign o_err_unexp = err_unexp_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

endmodule

// File: tb/tb_ofm_writeback.sv
// Directed bench for ofm_writeback: a cycle table for a basic layer plus
// hand-written sequences for stall, overflow, full-with-pop, stray and reset.
module tb_ofm_writeback;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 12;
    localparam int unsigned WS = 8;
    localparam int unsigned WC = 6;
    localparam int unsigned LW = 5;

    logic          clk;
    logic          rstn;
    logic          i_start;
    logic [WS-1:0] q_width;
    logic [WS-1:0] q_height;
    logic [WC-1:0] q_channel_out;
    logic          i_pp_data_vld;
    logic [DW-1:0] i_pp_data;
    logic [AW-1:0] i_pp_addr;
    logic          o_wr_vld;
    logic [DW-1:0] o_wr_data;
    logic [AW-1:0] o_wr_addr;
    logic          i_wr_rdy;
    logic          o_busy;
    logic          o_done;
    logic          o_overflow;
    logic          o_err_unexp;
    logic [LW-1:0] o_fifo_level;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];

    ofm_writeback dut (
        .clk           (clk),
        .rstn          (rstn),
        .i_start       (i_start),
        .q_width       (q_width),
        .q_height      (q_height),
        .q_channel_out (q_channel_out),
        .i_pp_data_vld (i_pp_data_vld),
        .i_pp_data     (i_pp_data),
        .i_pp_addr     (i_pp_addr),
        .o_wr_vld      (o_wr_vld),
        .o_wr_data     (o_wr_data),
        .o_wr_addr     (o_wr_addr),
        .i_wr_rdy      (i_wr_rdy),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_overflow    (o_overflow),
        .o_err_unexp   (o_err_unexp),
        .o_fifo_level  (o_fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every completed downstream handshake.
    always @(posedge clk) begin
        if (rstn && o_wr_vld && i_wr_rdy) begin
            wa_q.push_back(o_wr_addr);
            wd_q.push_back(o_wr_data);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          start;
        logic          vld;
        logic [AW-1:0] addr;
        logic          rdy;
        logic          ex_wv;
        logic [AW-1:0] ex_wa;
        logic [LW-1:0] ex_lvl;
        logic          ex_busy;
        logic          ex_done;
    } vec_t;

    vec_t tbl[9];

    function automatic logic [DW-1:0] dat(input int a);
        return 32'h5A00_0000 + DW'(a) * 32'd7;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic start_layer(input int w, input int h, input int c);
        q_width       = WS'(w);
        q_height      = WS'(h);
        q_channel_out = WC'(c);
        i_start       = 1'b1;
        tick();
        i_start       = 1'b0;
    endtask

    task automatic drive_word(input int a);
        i_pp_data_vld = 1'b1;
        i_pp_addr     = AW'(a);
        i_pp_data     = dat(a);
        tick();
        i_pp_data_vld = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < max_cyc && !seen; c++) begin
            tick();
            if (o_done) seen = 1'b1;
        end
        check({name, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic check_log(input string name, input int n, input int base);
        check({name, "_nwrites"}, 64'(wa_q.size()), 64'(n));
        for (int i = 0; i < n && i < wa_q.size(); i++) begin
            check($sformatf("%s_addr%0d", name, i), 64'(wa_q[i]), 64'(base + i));
            check($sformatf("%s_data%0d", name, i), 64'(wd_q[i]), 64'(dat(base + i)));
        end
    endtask

    initial begin
        rstn = 1'b0; i_start = 1'b0; i_pp_data_vld = 1'b0; i_pp_data = '0; i_pp_addr = '0;
        i_wr_rdy = 1'b0; q_width = '0; q_height = '0; q_channel_out = '0;

        // Basic layer 2x2x1: one table row per clock edge.
        tbl[0] = '{1'b1, 1'b0, 12'd0, 1'b1, 1'b0, 12'd0, 5'd0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 12'd0, 1'b1, 1'b0, 12'd0, 5'd1, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 12'd1, 1'b1, 1'b1, 12'd0, 5'd1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 12'd2, 1'b1, 1'b1, 12'd1, 5'd1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 12'd3, 1'b1, 1'b1, 12'd2, 5'd1, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 12'd0, 1'b1, 1'b1, 12'd3, 5'd0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 12'd0, 1'b1, 1'b0, 12'd0, 5'd0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 12'd0, 1'b1, 1'b0, 12'd0, 5'd0, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 12'd0, 1'b1, 1'b0, 12'd0, 5'd0, 1'b0, 1'b0};

        #12;
        check("rst_wr_vld",   64'(o_wr_vld),     64'd0);
        check("rst_wr_data",  64'(o_wr_data),    64'd0);
        check("rst_wr_addr",  64'(o_wr_addr),    64'd0);
        check("rst_busy",     64'(o_busy),       64'd0);
        check("rst_done",     64'(o_done),       64'd0);
        check("rst_overflow", 64'(o_overflow),   64'd0);
        check("rst_err",      64'(o_err_unexp),  64'd0);
        check("rst_level",    64'(o_fifo_level), 64'd0);
        #10 rstn = 1'b1;
        tick();

        q_width = 8'd2; q_height = 8'd2; q_channel_out = 6'd1;
        wa_q.delete(); wd_q.delete();
        for (int v = 0; v < 9; v++) begin
            i_start       = tbl[v].start;
            i_pp_data_vld = tbl[v].vld;
            i_pp_addr     = tbl[v].addr;
            i_pp_data     = dat(int'(tbl[v].addr));
            i_wr_rdy      = tbl[v].rdy;
            tick();
            check($sformatf("basic%0d_wr_vld", v), 64'(o_wr_vld), 64'(tbl[v].ex_wv));
            check($sformatf("basic%0d_level", v),  64'(o_fifo_level), 64'(tbl[v].ex_lvl));
            check($sformatf("basic%0d_busy", v),   64'(o_busy), 64'(tbl[v].ex_busy));
            check($sformatf("basic%0d_done", v),   64'(o_done), 64'(tbl[v].ex_done));
            if (tbl[v].ex_wv) begin
                check($sformatf("basic%0d_wr_addr", v), 64'(o_wr_addr), 64'(tbl[v].ex_wa));
                check($sformatf("basic%0d_wr_data", v), 64'(o_wr_data), 64'(dat(int'(tbl[v].ex_wa))));
            end
        end
        i_start = 1'b0; i_pp_data_vld = 1'b0;
        check("basic_overflow", 64'(o_overflow), 64'd0);
        check("basic_err",      64'(o_err_unexp), 64'd0);
        check_log("basic", 4, 0);

        // Back-pressure: 8 words against a stalled sink for 10 cycles.
        wa_q.delete(); wd_q.delete();
        i_wr_rdy = 1'b0;
        start_layer(8, 1, 1);
        for (int k = 1; k <= 10; k++) begin
            if (k <= 8) drive_word(16 + k - 1);
            else tick();
            check($sformatf("bp%0d_level", k), 64'(o_fifo_level), 64'((k <= 1) ? 1 : ((k <= 8) ? k - 1 : 7)));
            if (k >= 2) begin
                check($sformatf("bp%0d_wr_vld", k),  64'(o_wr_vld),  64'd1);
                check($sformatf("bp%0d_wr_addr", k), 64'(o_wr_addr), 64'd16);
                check($sformatf("bp%0d_wr_data", k), 64'(o_wr_data), 64'(dat(16)));
            end
        end
        i_wr_rdy = 1'b1;
        wait_done("bp", 50);
        check_log("bp", 8, 16);
        check("bp_overflow", 64'(o_overflow), 64'd0);

        // Overflow: 20 words, sink stalled; only 17 can be held.
        wa_q.delete(); wd_q.delete();
        i_wr_rdy = 1'b0;
        start_layer(20, 1, 1);
        for (int k = 0; k < 20; k++) begin
            drive_word(64 + k);
            if (k == 16) check("ovf_not_yet", 64'(o_overflow), 64'd0);
        end
        check("ovf_level",    64'(o_fifo_level), 64'd16);
        check("ovf_wr_vld",   64'(o_wr_vld),     64'd1);
        check("ovf_flag",     64'(o_overflow),   64'd1);
        check("ovf_busy",     64'(o_busy),       64'd1);
        i_wr_rdy = 1'b1;
        wait_done("ovf", 60);
        check_log("ovf", 17, 64);
        check("ovf_sticky", 64'(o_overflow), 64'd1);

        // Full FIFO with a simultaneous pop: the incoming word is kept.
        wa_q.delete(); wd_q.delete();
        i_wr_rdy = 1'b0;
        start_layer(18, 1, 1);
        check("fp_ovf_cleared", 64'(o_overflow), 64'd0);
        for (int k = 0; k < 17; k++) drive_word(128 + k);
        check("fp_full_level", 64'(o_fifo_level), 64'd16);
        i_wr_rdy = 1'b1;
        drive_word(128 + 17);
        check("fp_level",    64'(o_fifo_level), 64'd16);
        check("fp_overflow", 64'(o_overflow),   64'd0);
        check("fp_wr_addr",  64'(o_wr_addr),    64'(128 + 1));
        wait_done("fp", 60);
        check_log("fp", 18, 128);

        // Empty layer, then stray traffic while idle.
        wa_q.delete(); wd_q.delete();
        start_layer(3, 0, 2);
        check("zero_done_e0", 64'(o_done), 64'd0);
        check("zero_busy_e0", 64'(o_busy), 64'd0);
        tick();
        check("zero_done_e1", 64'(o_done), 64'd1);
        tick();
        check("zero_done_e2", 64'(o_done), 64'd0);
        drive_word(300);
        check("stray_err",    64'(o_err_unexp),  64'd1);
        check("stray_wr_vld", 64'(o_wr_vld),     64'd0);
        check("stray_level",  64'(o_fifo_level), 64'd0);
        tick();
        check("stray_wr_vld2", 64'(o_wr_vld), 64'd0);
        check("stray_nwrites", 64'(wa_q.size()), 64'd0);

        // Async reset while running with five words queued.
        i_wr_rdy = 1'b0;
        start_layer(10, 1, 1);
        check("rr_err_cleared", 64'(o_err_unexp), 64'd0);
        for (int k = 0; k < 6; k++) drive_word(400 + k);
        check("rr_level_pre",  64'(o_fifo_level), 64'd5);
        check("rr_wr_vld_pre", 64'(o_wr_vld),     64'd1);
        #2 rstn = 1'b0;
        #1;
        check("rr_wr_vld",  64'(o_wr_vld),     64'd0);
        check("rr_level",   64'(o_fifo_level), 64'd0);
        check("rr_busy",    64'(o_busy),       64'd0);
        tick();
        tick();
        #2 rstn = 1'b1;
        i_wr_rdy = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        check("rr_nwrites", 64'(wa_q.size()), 64'd0);
        check("rr_wr_vld_post", 64'(o_wr_vld), 64'd0);
        check("rr_busy_post",   64'(o_busy),   64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
